// File: rtl/snitch_tcdm_bank_responder_pkg.sv
// Shared types for the TCDM bank responder: AMO opcodes, bank FSM states and
// the default request/response structs for a 32-bit bank.
package snitch_tcdm_bank_responder_pkg;

    // Atomic memory operation opcodes as carried on the request channel.
    typedef enum logic [3:0] {
        AMONone = 4'h0,
        AMOSwap = 4'h1,
        AMOAdd  = 4'h2,
        AMOAnd  = 4'h3,
        AMOOr   = 4'h4,
        AMOXor  = 4'h5,
        AMOMax  = 4'h6,
        AMOMaxu = 4'h7,
        AMOMin  = 4'h8,
        AMOMinu = 4'h9,
        AMOLR   = 4'hA,
        AMOSC   = 4'hB
    } amo_op_e;

    // Bank FSM: Idle accepts requests, AmoWrite commits a read-modify-write.
    typedef enum logic [0:0] {
        Idle     = 1'b0,
        AmoWrite = 1'b1
    } tcdm_bank_state_e;

    localparam int unsigned DefAddrWidth = 32;
    localparam int unsigned DefDataWidth = 32;
    localparam int unsigned DefUserWidth = 4;

    typedef struct packed {
        logic [DefAddrWidth-1:0]   addr;
        logic                      write;
        amo_op_e                   amo;
        logic [DefDataWidth-1:0]   data;
        logic [DefDataWidth/8-1:0] strb;
        logic [DefUserWidth-1:0]   user;
    } tcdm_req_chan_t;

    typedef struct packed {
        tcdm_req_chan_t q;
        logic           q_valid;
    } tcdm_mem_req_t;

    typedef struct packed {
        logic [DefDataWidth-1:0] data;
    } tcdm_rsp_chan_t;

    typedef struct packed {
        tcdm_rsp_chan_t p;
        logic           q_ready;
    } tcdm_mem_rsp_t;

    // True for the opcodes the bank executes as read-modify-write.
    // LR/SC are unsupported and fall back to plain reads.
    function automatic logic is_rmw_amo(amo_op_e op);
        logic res;
        case (op)
            AMOSwap, AMOAdd, AMOAnd, AMOOr, AMOXor,
            AMOMax, AMOMaxu, AMOMin, AMOMinu: res = 1'b1;
            default:                          res = 1'b0;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/snitch_tcdm_bank_responder_amo_alu.sv
// Combinational AMO ALU: computes the new word from the old word and the
// request operand. Reusable by any AMO-capable memory endpoint.
module snitch_amo_alu
    import snitch_tcdm_bank_responder_pkg::*;
#(
    parameter int unsigned DataWidth = 32
) (
    input  amo_op_e              amo_op,
    input  logic [DataWidth-1:0] old_word,
    input  logic [DataWidth-1:0] operand,
    output logic [DataWidth-1:0] result
);

    logic old_gt_signed_s;
    logic old_gt_unsigned_s;

    assign old_gt_signed_s   = $signed(old_word) > $signed(operand);
    assign old_gt_unsigned_s = old_word > operand;

    // Select the read-modify-write result; unknown opcodes keep the old word.
    always_comb begin
        result = old_word;
        case (amo_op)
            AMOSwap: result = operand;
            AMOAdd:  result = old_word + operand;
            AMOAnd:  result = old_word & operand;
            AMOOr:   result = old_word | operand;
            AMOXor:  result = old_word ^ operand;
            AMOMax: begin
                if (old_gt_signed_s) result = old_word;
                else                 result = operand;
            end
            AMOMaxu: begin
                if (old_gt_unsigned_s) result = old_word;
                else                   result = operand;
            end
            AMOMin: begin
                if (old_gt_signed_s) result = operand;
                else                 result = old_word;
            end
            AMOMinu: begin
                if (old_gt_unsigned_s) result = operand;
                else                   result = old_word;
            end
            default: result = old_word;
        endcase
    end

endmodule

// File: rtl/snitch_tcdm_bank_responder_chk.sv
// Protocol checks for the bank responder: address range, AMO strobes,
// unsupported opcodes and X-free accepted requests.
module snitch_tcdm_bank_responder_chk
    import snitch_tcdm_bank_responder_pkg::*;
#(
    parameter int unsigned NumWords  = 1024,
    parameter int unsigned AddrWidth = 32,
    parameter int unsigned StrbWidth = 4,
    parameter int unsigned ReqWidth  = 1
) (
    input logic                 clk_i,
    input logic                 rst_i,
    input logic                 hs,
    input logic [AddrWidth-1:0] addr,
    input amo_op_e              amo,
    input logic [StrbWidth-1:0] strb,
    input logic [ReqWidth-1:0]  req_bits
);

    addr_in_range_a: assert property (@(posedge clk_i) disable iff (rst_i)
        hs |-> (64'(addr) < 64'(NumWords)));

    amo_full_strobe_a: assert property (@(posedge clk_i) disable iff (rst_i)
        (hs && is_rmw_amo(amo)) |-> (strb == {StrbWidth{1'b1}}));

    amo_lrsc_unsupported_a: assert property (@(posedge clk_i) disable iff (rst_i)
        hs |-> !(amo == AMOLR || amo == AMOSC));

    req_known_a: assert property (@(posedge clk_i) disable iff (rst_i)
        hs |-> !$isunknown(req_bits));

endmodule

// File: rtl/snitch_tcdm_bank_responder.sv
// Memory-side responder for one TCDM bank port. Holds the bank storage,
// executes reads, byte-strobed writes and two-cycle AMOs, and returns the
// pre-operation word a fixed number of cycles after each handshake.
module snitch_tcdm_bank_responder
    import snitch_tcdm_bank_responder_pkg::*;
#(
    parameter int unsigned NumWords              = 1024,
    parameter int unsigned DataWidth             = 32,
    parameter int unsigned MemAddrWidth          = 32,
    parameter int unsigned MemoryResponseLatency = 1,
    parameter type         mem_req_t             = tcdm_mem_req_t,
    parameter type         mem_rsp_t             = tcdm_mem_rsp_t
) (
    input  logic     clk_i,
    input  logic     rst_i,
    input  mem_req_t mem_req_i,
    output mem_rsp_t mem_rsp_o
);

    localparam int unsigned IdxWidth  = $clog2(NumWords);
    localparam int unsigned StrbWidth = DataWidth / 8;

    tcdm_bank_state_e     state_r;
    logic                 ready_r;
    logic [DataWidth-1:0] mem_r [NumWords];

    logic [IdxWidth-1:0]  amo_idx_r;
    logic [DataWidth-1:0] amo_old_r;
    logic [DataWidth-1:0] amo_operand_r;
    amo_op_e              amo_op_r;

    logic [DataWidth-1:0] pipe_r [MemoryResponseLatency];

    logic                 q_ready_s;
    logic                 hs_s;
    logic [IdxWidth-1:0]  idx_s;
    logic                 amo_req_s;
    logic                 write_req_s;
    logic [DataWidth-1:0] rdata_s;
    logic [DataWidth-1:0] stage_in_s;
    logic [DataWidth-1:0] alu_res_s;

    // Ready depends only on the FSM and reset, never on q_valid.
    assign q_ready_s = ready_r & ~rst_i;
    assign hs_s      = mem_req_i.q_valid & q_ready_s;
    assign idx_s     = mem_req_i.q.addr[IdxWidth-1:0];
    assign rdata_s   = mem_r[idx_s];

    // Classify the request: RMW AMOs, plain writes; everything else reads.
    always_comb begin
        amo_req_s   = is_rmw_amo(mem_req_i.q.amo);
        write_req_s = 1'b0;
        if (mem_req_i.q.write && (mem_req_i.q.amo == AMONone)) begin
            write_req_s = 1'b1;
        end else begin
            write_req_s = 1'b0;
        end
    end

    // Feed the pipeline with the handshake read, zero otherwise.
    always_comb begin
        stage_in_s = {DataWidth{1'b0}};
        if (hs_s) begin
            stage_in_s = rdata_s;
        end else begin
            stage_in_s = {DataWidth{1'b0}};
        end
    end

    snitch_amo_alu #(
        .DataWidth (DataWidth)
    ) i_amo_alu (
        .amo_op   (amo_op_r),
        .old_word (amo_old_r),
        .operand  (amo_operand_r),
        .result   (alu_res_s)
    );

    // Bank FSM: an accepted AMO parks the bank for one write-back cycle.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_r <= Idle;
            ready_r <= 1'b1;
        end else begin
            case (state_r)
                Idle: begin
                    if (hs_s && amo_req_s) begin
                        state_r       <= AmoWrite;
                        ready_r       <= 1'b0;
                        amo_idx_r     <= idx_s;
                        amo_old_r     <= rdata_s;
                        amo_operand_r <= mem_req_i.q.data;
                        amo_op_r      <= mem_req_i.q.amo;
                    end else begin
                        state_r <= Idle;
                        ready_r <= 1'b1;
                    end
                end
                AmoWrite: begin
                    state_r <= Idle;
                    ready_r <= 1'b1;
                end
                default: begin
                    state_r <= Idle;
                    ready_r <= 1'b1;
                end
            endcase
        end
    end

    // Storage update: AMO write-back (dropped by reset) or byte-strobed write.
    always_ff @(posedge clk_i) begin
        if (!rst_i && (state_r == AmoWrite)) begin
            mem_r[amo_idx_r] <= alu_res_s;
        end else if (hs_s && write_req_s) begin
            for (int b = 0; b < StrbWidth; b++) begin
                if (mem_req_i.q.strb[b]) begin
                    mem_r[idx_s][b*8 +: 8] <= mem_req_i.q.data[b*8 +: 8];
                end
            end
        end
    end

    // Response delay line: stage 0 takes the handshake read data.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < MemoryResponseLatency; i++) begin
                pipe_r[i] <= {DataWidth{1'b0}};
            end
        end else begin
            pipe_r[0] <= stage_in_s;
            for (int i = 1; i < MemoryResponseLatency; i++) begin
                pipe_r[i] <= pipe_r[i-1];
            end
        end
    end

    // Pack the response struct from the pipeline tail and ready.
    always_comb begin
        mem_rsp_o         = '0;
        mem_rsp_o.p.data  = pipe_r[MemoryResponseLatency-1];
        mem_rsp_o.q_ready = q_ready_s;
    end

    snitch_tcdm_bank_responder_chk #(
        .NumWords  (NumWords),
        .AddrWidth (MemAddrWidth),
        .StrbWidth (StrbWidth),
        .ReqWidth  ($bits(mem_req_t))
    ) i_chk (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .hs       (hs_s),
        .addr     (mem_req_i.q.addr),
        .amo      (mem_req_i.q.amo),
        .strb     (mem_req_i.q.strb),
        .req_bits (mem_req_i)
    );

endmodule
